// File: rtl/minesweeper_game_ctrl.sv
// ---------------------------------------------------------------------------
// minesweeper_game_ctrl
//
// Game-flow controller for an 8x8 minesweeper board. It owns the cursor, the
// flag/reveal counters and the win/lose decision. The board itself lives
// outside this block. It is addressed by the cursor, and its status comes back
// on the cell_* inputs in the same cycle.
//
// Optional build macro:
//   FLAG_LIMIT_EN  when defined, no new flag may be placed once flags_cnt
//                  equals the effective bomb count. When undefined, flagging
//                  is unlimited. Removing a flag is always allowed.
//
// Parameters:
//   MAX_BOMBS      upper clamp on the effective bomb count (default 63)
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   bombs_cfg      requested bomb count, latched on the start edge in SETUP
//   start          start/restart button
//   move_btn, dir  move the cursor one cell (00 up, 01 down, 10 left, 11 right)
//   select_btn     reveal the cursor cell
//   mark_btn       toggle the flag on the cursor cell
//   place_req      bomb-placement request (high for the whole PLACE state)
//   place_done     placement-complete pulse from the board
//   cur_row/col    cursor position, also the board lookup address
//   cell_is_bomb, cell_revealed, cell_flagged
//                  status of the cursor cell, same cycle
//   reveal_we      one-cycle pulse: reveal the cursor cell
//   flag_we        one-cycle pulse: toggle the flag of the cursor cell
//   state_out      current FSM state (encoding below)
//   win, lose      held high while in the WIN / LOSE state
//   flags_cnt      number of flagged cells
//   revealed_cnt   number of safe cells revealed
// ---------------------------------------------------------------------------
module minesweeper_game_ctrl #(
    parameter int MAX_BOMBS = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] bombs_cfg,
    input  logic       start,
    input  logic       move_btn,
    input  logic [1:0] dir,
    input  logic       select_btn,
    input  logic       mark_btn,
    output logic       place_req,
    input  logic       place_done,
    output logic [2:0] cur_row,
    output logic [2:0] cur_col,
    input  logic       cell_is_bomb,
    input  logic       cell_revealed,
    input  logic       cell_flagged,
    output logic       reveal_we,
    output logic       flag_we,
    output logic [2:0] state_out,
    output logic       win,
    output logic       lose,
    output logic [6:0] flags_cnt,
    output logic [6:0] revealed_cnt
);

    typedef enum logic [2:0] {
        S_SETUP  = 3'd0,
        S_PLACE  = 3'd1,
        S_WAIT   = 3'd2,
        S_MOVE   = 3'd3,
        S_SELECT = 3'd4,
        S_MARK   = 3'd5,
        S_WIN    = 3'd6,
        S_LOSE   = 3'd7
    } state_t;

    localparam logic [5:0] MAX_B = 6'(MAX_BOMBS);

    state_t     state, state_next;

    // Button history. Reset to 1 so that a button held through reset does
    // not look like a fresh press.
    logic       start_q, move_q, select_q, mark_q;
    logic       start_rise, move_rise, select_rise, mark_rise;

    logic [5:0] bombs_eff;
    logic [5:0] bombs_req;
    logic [6:0] safe_cnt;
    logic [6:0] revealed_next;

    // Datapath controls, decoded by the FSM.
    logic       do_latch;
    logic       do_clear;
    logic       do_move;
    logic       do_reveal_inc;
    logic       do_flag_inc;
    logic       do_flag_dec;
    logic       flag_ok;

    assign start_rise  = start      & ~start_q;
    assign move_rise   = move_btn   & ~move_q;
    assign select_rise = select_btn & ~select_q;
    assign mark_rise   = mark_btn   & ~mark_q;

    assign revealed_next = revealed_cnt + 7'd1;

    // Effective bomb count: at least one bomb, never more than MAX_BOMBS.
    always_comb begin
        bombs_req = bombs_cfg;
        if (bombs_cfg == 6'd0) begin
            bombs_req = 6'd1;
        end else if (bombs_cfg > MAX_B) begin
            bombs_req = MAX_B;
        end
    end

`ifdef FLAG_LIMIT_EN
    assign flag_ok = (flags_cnt != {1'b0, bombs_eff});
`else
    assign flag_ok = 1'b1;
`endif

    // Placement handshake: place_req is a level that stays high for the
    // whole PLACE state. The board answers with a place_done pulse, and the
    // request drops on the same edge that moves the FSM on. A reset during
    // PLACE drops place_req at once because it decodes directly from state.
    assign place_req = (state == S_PLACE);
    assign win       = (state == S_WIN);
    assign lose      = (state == S_LOSE);
    assign state_out = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_SETUP;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        do_latch      = 1'b0;
        do_clear      = 1'b0;
        do_move       = 1'b0;
        do_reveal_inc = 1'b0;
        do_flag_inc   = 1'b0;
        do_flag_dec   = 1'b0;
        reveal_we     = 1'b0;
        flag_we       = 1'b0;
        case (state)
            S_SETUP: begin
                if (start_rise) begin
                    do_latch   = 1'b1;
                    state_next = S_PLACE;
                end
            end
            S_PLACE: begin
                if (place_done) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // Only one action is taken per visit. Other edges seen in
                // the same cycle are dropped.
                if (select_rise) begin
                    state_next = S_SELECT;
                end else if (mark_rise) begin
                    state_next = S_MARK;
                end else if (move_rise) begin
                    state_next = S_MOVE;
                end
            end
            S_MOVE: begin
                do_move    = 1'b1;
                state_next = S_WAIT;
            end
            S_SELECT: begin
                state_next = S_WAIT;
                if (!cell_revealed && !cell_flagged) begin
                    reveal_we = 1'b1;
                    if (cell_is_bomb) begin
                        state_next = S_LOSE;
                    end else begin
                        do_reveal_inc = 1'b1;
                        if (revealed_next == safe_cnt) begin
                            state_next = S_WIN;
                        end
                    end
                end
            end
            S_MARK: begin
                state_next = S_WAIT;
                if (!cell_revealed) begin
                    if (cell_flagged) begin
                        flag_we     = 1'b1;
                        do_flag_dec = 1'b1;
                    end else if (flag_ok) begin
                        flag_we     = 1'b1;
                        do_flag_inc = 1'b1;
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (start_rise) begin
                    do_clear   = 1'b1;
                    state_next = S_SETUP;
                end
            end
            default: state_next = S_SETUP;
        endcase
    end

    // The button history keeps updating in every state. This is why edges
    // that arrive during MOVE/SELECT/MARK are dropped rather than deferred.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q  <= 1'b1;
            move_q   <= 1'b1;
            select_q <= 1'b1;
            mark_q   <= 1'b1;
        end else begin
            start_q  <= start;
            move_q   <= move_btn;
            select_q <= select_btn;
            mark_q   <= mark_btn;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bombs_eff <= 6'd1;
            safe_cnt  <= 7'd63;
        end else if (do_latch) begin
            bombs_eff <= bombs_req;
            safe_cnt  <= 7'd64 - {1'b0, bombs_req};
        end
    end

    // The 3-bit cursor wraps 0<->7 through plain modular arithmetic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_row <= 3'd0;
            cur_col <= 3'd0;
        end else if (do_clear) begin
            cur_row <= 3'd0;
            cur_col <= 3'd0;
        end else if (do_move) begin
            case (dir)
                2'b00:   cur_row <= cur_row - 3'd1;
                2'b01:   cur_row <= cur_row + 3'd1;
                2'b10:   cur_col <= cur_col - 3'd1;
                default: cur_col <= cur_col + 3'd1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            revealed_cnt <= 7'd0;
            flags_cnt    <= 7'd0;
        end else if (do_clear) begin
            revealed_cnt <= 7'd0;
            flags_cnt    <= 7'd0;
        end else begin
            if (do_reveal_inc) begin
                revealed_cnt <= revealed_next;
            end
            // Saturate at zero in case the board reports a flag that this
            // counter never saw, for example after a partial restart.
            if (do_flag_inc) begin
                flags_cnt <= flags_cnt + 7'd1;
            end else if (do_flag_dec && (flags_cnt != 7'd0)) begin
                flags_cnt <= flags_cnt - 7'd1;
            end
        end
    end

endmodule

// File: tb/tb_minesweeper_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_minesweeper_game_ctrl
//
// Bench for minesweeper_game_ctrl. It contains a behavioural board (bomb,
// revealed and flagged bitmaps) and a game-level reference model that
// applies the game rules to whole button actions. It covers reset
// behaviour, the placement handshake, cursor wrap, button priority, win
// and lose, the bomb clamp and flag limiting, plus randomized games.
// ---------------------------------------------------------------------------
module tb_minesweeper_game_ctrl;

    localparam int MAX_BOMBS = 63;
    localparam int ST_SETUP  = 0;
    localparam int ST_PLACE  = 1;
    localparam int ST_WAIT   = 2;
    localparam int ST_WIN    = 6;
    localparam int ST_LOSE   = 7;
`ifdef FLAG_LIMIT_EN
    localparam bit FLAG_LIMIT = 1'b1;
`else
    localparam bit FLAG_LIMIT = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] bombs_cfg;
    logic       start, move_btn, select_btn, mark_btn, place_done;
    logic [1:0] dir;
    logic       place_req, reveal_we, flag_we, win, lose;
    logic [2:0] cur_row, cur_col, state_out;
    logic       cell_is_bomb, cell_revealed, cell_flagged;
    logic [6:0] flags_cnt, revealed_cnt;

    always #5 clk = ~clk;

    minesweeper_game_ctrl #(.MAX_BOMBS(MAX_BOMBS)) dut (
        .clk          (clk),
        .rst          (rst),
        .bombs_cfg    (bombs_cfg),
        .start        (start),
        .move_btn     (move_btn),
        .dir          (dir),
        .select_btn   (select_btn),
        .mark_btn     (mark_btn),
        .place_req    (place_req),
        .place_done   (place_done),
        .cur_row      (cur_row),
        .cur_col      (cur_col),
        .cell_is_bomb (cell_is_bomb),
        .cell_revealed(cell_revealed),
        .cell_flagged (cell_flagged),
        .reveal_we    (reveal_we),
        .flag_we      (flag_we),
        .state_out    (state_out),
        .win          (win),
        .lose         (lose),
        .flags_cnt    (flags_cnt),
        .revealed_cnt (revealed_cnt)
    );

    // ---------------- behavioural board ----------------
    logic [63:0] b_bomb = '0;
    logic [63:0] b_rev  = '0;
    logic [63:0] b_flag = '0;
    logic [5:0]  cidx;

    assign cidx          = {cur_row, cur_col};
    assign cell_is_bomb  = b_bomb[cidx];
    assign cell_revealed = b_rev[cidx];
    assign cell_flagged  = b_flag[cidx];

    int rev_pulses  = 0;
    int flag_pulses = 0;
    int preq_cycles = 0;
    int both_cnt    = 0;

    always @(posedge clk) begin
        if (place_req) preq_cycles <= preq_cycles + 1;
        if (reveal_we) begin
            rev_pulses  <= rev_pulses + 1;
            b_rev[cidx] <= 1'b1;
        end
        if (flag_we) begin
            flag_pulses  <= flag_pulses + 1;
            b_flag[cidx] <= ~b_flag[cidx];
        end
        if (reveal_we && flag_we) both_cnt <= both_cnt + 1;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_state, m_row, m_col, m_flags, m_rev, m_eff, m_safe;
    logic [63:0] m_revd, m_flagd;

    task automatic model_reset();
        m_state = ST_SETUP;
        m_row = 0; m_col = 0; m_flags = 0; m_rev = 0;
        m_eff = 1; m_safe = 63;
    endtask

    task automatic check_all(input string tag);
        check({tag, "/state"},    state_out,    m_state);
        check({tag, "/row"},      cur_row,      m_row);
        check({tag, "/col"},      cur_col,      m_col);
        check({tag, "/flags"},    flags_cnt,    m_flags);
        check({tag, "/revealed"}, revealed_cnt, m_rev);
        check({tag, "/win"},      win,          (m_state == ST_WIN));
        check({tag, "/lose"},     lose,         (m_state == ST_LOSE));
        check({tag, "/place_req"}, place_req,   (m_state == ST_PLACE));
        if (m_state != ST_SETUP) begin
            check({tag, "/board_rev"},  b_rev,  m_revd);
            check({tag, "/board_flag"}, b_flag, m_flagd);
        end
    endtask

    task automatic place_bombs(input int n);
        int cnt;
        int p;
        b_bomb = '0;
        cnt = 0;
        while (cnt < n) begin
            p = $urandom_range(0, 63);
            if (!b_bomb[p]) begin
                b_bomb[p] = 1'b1;
                cnt++;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // One button action: drive the requested buttons for one cycle, let the
    // controller settle, then apply the same action to the model and compare.
    task automatic press(input string tag, input bit s, input bit mk, input bit mv,
                         input bit st, input logic [1:0] d);
        int r0, f0, exp_r, exp_f, idx;
        r0 = rev_pulses; f0 = flag_pulses; exp_r = 0; exp_f = 0;
        dir = d; select_btn = s; mark_btn = mk; move_btn = mv; start = st;
        @(posedge clk); #1;
        select_btn = 0; mark_btn = 0; move_btn = 0; start = 0;
        repeat (3) @(posedge clk);
        #1;
        idx = m_row * 8 + m_col;
        if (m_state == ST_WAIT) begin
            if (s) begin
                if (!m_revd[idx] && !m_flagd[idx]) begin
                    exp_r = 1;
                    m_revd[idx] = 1'b1;
                    if (b_bomb[idx]) m_state = ST_LOSE;
                    else begin
                        m_rev++;
                        if (m_rev == m_safe) m_state = ST_WIN;
                    end
                end
            end else if (mk) begin
                if (!m_revd[idx]) begin
                    if (m_flagd[idx]) begin
                        exp_f = 1; m_flagd[idx] = 1'b0; m_flags--;
                    end else if (!FLAG_LIMIT || m_flags < m_eff) begin
                        exp_f = 1; m_flagd[idx] = 1'b1; m_flags++;
                    end
                end
            end else if (mv) begin
                case (d)
                    2'b00:   m_row = (m_row + 7) % 8;
                    2'b01:   m_row = (m_row + 1) % 8;
                    2'b10:   m_col = (m_col + 7) % 8;
                    default: m_col = (m_col + 1) % 8;
                endcase
            end
        end else if ((m_state == ST_WIN || m_state == ST_LOSE) && st) begin
            m_state = ST_SETUP; m_row = 0; m_col = 0; m_flags = 0; m_rev = 0;
        end
        check({tag, "/reveal_pulses"}, rev_pulses - r0, exp_r);
        check({tag, "/flag_pulses"},   flag_pulses - f0, exp_f);
        check_all(tag);
    endtask

    task automatic sel(input string tag);            press(tag, 1, 0, 0, 0, 2'b00); endtask
    task automatic mrk(input string tag);            press(tag, 0, 1, 0, 0, 2'b00); endtask
    task automatic mv(input string tag, input logic [1:0] d); press(tag, 0, 0, 1, 0, d); endtask
    task automatic restart(input string tag);        press(tag, 0, 0, 0, 1, 2'b00); endtask

    // Start edge from SETUP, then answer the placement request after 'delay'
    // cycles of place_req.
    task automatic start_game(input int cfg, input int delay);
        int p0;
        bombs_cfg = 6'(cfg);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        check("start/state_place", state_out, ST_PLACE);
        b_rev  <= '0;
        b_flag <= '0;
        m_revd  = '0;
        m_flagd = '0;
        p0 = preq_cycles;
        repeat (delay - 1) @(posedge clk);
        #1 place_done = 1;
        @(posedge clk); #1;
        place_done = 0;
        check("start/place_req_cycles", preq_cycles - p0, delay);
        m_eff   = (cfg == 0) ? 1 : ((cfg > MAX_BOMBS) ? MAX_BOMBS : cfg);
        m_safe  = 64 - m_eff;
        m_state = ST_WAIT;
        place_bombs(m_eff);
        check_all("start");
    endtask

    // Asynchronous reset from the middle of a cycle; the outputs are checked
    // before the next clock edge.
    task automatic do_reset();
        #2 rst = 1;
        #1;
        model_reset();
        check("reset/state_now",     state_out, ST_SETUP);
        check("reset/place_req_now", place_req, 0);
        check("reset/counts_now",    {flags_cnt, revealed_cnt}, 0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        check_all("reset");
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int exp_flags;
        int r;
        rst = 1; start = 1; move_btn = 1; select_btn = 1; mark_btn = 1;
        dir = 2'b00; place_done = 0; bombs_cfg = 6'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        check_all("por");
        // Buttons held through reset must not produce edges.
        repeat (3) @(posedge clk);
        #1;
        check("held_start/state", state_out, ST_SETUP);
        start = 0; move_btn = 0; select_btn = 0; mark_btn = 0;
        @(posedge clk); #1;

        // Placement handshake, ten bombs, five cycles of place_req.
        start_game(10, 5);
        check("cfg10/state_wait", state_out, ST_WAIT);

        // Cursor wrap: up from row 0, then left from column 0.
        mv("wrap_up", 2'b00);
        check("wrap_up/pos", {cur_row, cur_col}, {3'd7, 3'd0});
        mv("wrap_left", 2'b10);
        check("wrap_left/pos", {cur_row, cur_col}, {3'd7, 3'd7});
        mv("wrap_down", 2'b01);
        mv("wrap_right", 2'b11);

        // Select and move on the same edge: select wins, move is dropped.
        b_bomb[m_row * 8 + m_col] = 1'b0;
        press("sel_move", 1, 0, 1, 0, 2'b11);
        check("sel_move/revealed", revealed_cnt, 1);

        // Select on a bomb, then later actions are ignored.
        do_reset();
        start_game(5, 1);
        b_bomb = 64'h1;
        sel("lose_sel");
        check("lose/flag", lose, 1);
        sel("lose_sel2");
        mrk("lose_mrk");
        mv("lose_mv", 2'b01);
        restart("lose_restart");

        // Minimum bomb count: reveal all 63 safe cells.
        start_game(0, 3);
        b_bomb = 64'h8000_0000_0000_0000;
        for (int rr = 0; rr < 8; rr++) begin
            for (int cc = 0; cc < 8; cc++) begin
                if (m_state == ST_WAIT) begin
                    if (!(rr == 7 && cc == 7)) sel("sweep_sel");
                    mv("sweep_mv", 2'b11);
                end
            end
            if (m_state == ST_WAIT) mv("sweep_down", 2'b01);
        end
        check("sweep/win", win, 1);
        check("sweep/state", state_out, ST_WIN);
        check("sweep/revealed", revealed_cnt, 63);
        restart("win_restart");
        check("win_restart/counts", {flags_cnt, revealed_cnt}, 0);

        // Maximum bomb count: a single safe cell wins at once.
        start_game(63, 2);
        b_bomb = ~64'h1;
        sel("max_sel");
        check("max/win", win, 1);
        restart("max_restart");

        // Flag limit with two bombs: mark three cells.
        start_game(2, 2);
        b_bomb = '0;
        r = flag_pulses;
        mrk("flag1");
        mv("flag_mv1", 2'b11);
        mrk("flag2");
        mv("flag_mv2", 2'b11);
        mrk("flag3");
        exp_flags = FLAG_LIMIT ? 2 : 3;
        check("flag3/pulses", flag_pulses - r, exp_flags);
        check("flag3/count", flags_cnt, exp_flags);
        mv("flag_back", 2'b10);
        mrk("unflag");
        sel("sel_unflagged");
        mrk("mark_revealed");
        mv("flag_fwd", 2'b11);
        sel("sel_maybe_flagged");

        // Randomized games against the model.
        for (int g = 0; g < 6; g++) begin
            do_reset();
            start_game($urandom_range(0, 12), $urandom_range(1, 6));
            for (int k = 0; k < 50; k++) begin
                r = $urandom_range(0, 7);
                case (r)
                    0, 1, 2: mv("rnd_mv", 2'($urandom_range(0, 3)));
                    3:       sel("rnd_sel");
                    4, 7:    mrk("rnd_mrk");
                    5:       press("rnd_combo", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                   1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 3)));
                    default: press("rnd_start_ignored", 0, 0, 0, 1, 2'b00);
                endcase
                if (m_state == ST_WIN || m_state == ST_LOSE) begin
                    restart("rnd_restart");
                    start_game($urandom_range(0, 12), $urandom_range(1, 4));
                end
            end
        end

        // Reset while placement is pending drops the request at once.
        do_reset();
        bombs_cfg = 6'd4;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        check("abort/place_req_before", place_req, 1);
        do_reset();

        check("reveal_and_flag_overlap", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
